// File: rtl/circular_dma_wr_arbiter.sv
// Two-requester AXI4 write arbiter for circular DMA engines: round-robin at burst
// granularity, grant held AW through B, wlast regenerated from a beat counter.
module circular_dma_wr_arbiter #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester 0
  input  logic [C_ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [7:0]              s0_axi_awlen,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [C_DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic                    s0_axi_wlast,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  // requester 1
  input  logic [C_ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [7:0]              s1_axi_awlen,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [C_DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic                    s1_axi_wlast,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  // shared master
  output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [C_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // status
  output logic                    grant,
  output logic                    busy,
  output logic [1:0]              err_wlast
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; valid never
  // waits on ready, and only the granted requester's channel for the current phase is open.
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e     state_q;
  logic       grant_q;
  logic       last_grant_q;
  logic [7:0] cnt_q;
  logic [1:0] err_q;

  logic [C_ADDR_WIDTH-1:0] sel_awaddr;
  logic [7:0]              sel_awlen;
  logic                    sel_awvalid;
  logic [C_DATA_WIDTH-1:0] sel_wdata;
  logic                    sel_wlast;
  logic                    sel_wvalid;
  logic                    sel_bready;

  assign sel_awaddr  = grant_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign sel_awlen   = grant_q ? s1_axi_awlen   : s0_axi_awlen;
  assign sel_awvalid = grant_q ? s1_axi_awvalid : s0_axi_awvalid;
  assign sel_wdata   = grant_q ? s1_axi_wdata   : s0_axi_wdata;
  assign sel_wlast   = grant_q ? s1_axi_wlast   : s0_axi_wlast;
  assign sel_wvalid  = grant_q ? s1_axi_wvalid  : s0_axi_wvalid;
  assign sel_bready  = grant_q ? s1_axi_bready  : s0_axi_bready;

  logic in_addr, in_data, in_resp;
  logic aw_hs, w_hs, b_hs;
  logic last_beat;

  assign in_addr   = (state_q == S_ADDR);
  assign in_data   = (state_q == S_DATA);
  assign in_resp   = (state_q == S_RESP);
  assign aw_hs     = in_addr && sel_awvalid && m_axi_awready;
  assign w_hs      = in_data && sel_wvalid && m_axi_wready;
  assign b_hs      = in_resp && m_axi_bvalid && sel_bready;
  assign last_beat = (cnt_q == 8'd0);

  // Payloads are zeroed outside their phase so idle buses show no stale requester data.
  assign m_axi_awaddr  = in_addr ? sel_awaddr : '0;
  assign m_axi_awlen   = in_addr ? sel_awlen  : 8'd0;
  assign m_axi_awvalid = in_addr && sel_awvalid;
  assign m_axi_wdata   = in_data ? sel_wdata  : '0;
  assign m_axi_wlast   = in_data && last_beat;
  assign m_axi_wvalid  = in_data && sel_wvalid;
  assign m_axi_bready  = in_resp && sel_bready;

  assign s0_axi_awready = in_addr && !grant_q && m_axi_awready;
  assign s1_axi_awready = in_addr &&  grant_q && m_axi_awready;
  assign s0_axi_wready  = in_data && !grant_q && m_axi_wready;
  assign s1_axi_wready  = in_data &&  grant_q && m_axi_wready;
  assign s0_axi_bvalid  = in_resp && !grant_q && m_axi_bvalid;
  assign s1_axi_bvalid  = in_resp &&  grant_q && m_axi_bvalid;
  assign s0_axi_bresp   = (in_resp && !grant_q) ? m_axi_bresp : 2'b00;
  assign s1_axi_bresp   = (in_resp &&  grant_q) ? m_axi_bresp : 2'b00;

  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign err_wlast = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
      err_q        <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s0_axi_awvalid || s1_axi_awvalid) begin
            if (s0_axi_awvalid && s1_axi_awvalid) grant_q <= ~last_grant_q;
            else                                  grant_q <= s1_axi_awvalid;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (aw_hs) begin
            cnt_q   <= sel_awlen;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            // Requester's wlast is only audited; the counter alone ends the burst.
            if (sel_wlast != last_beat) err_q[grant_q] <= 1'b1;
            if (last_beat) state_q <= S_RESP;
            else           cnt_q   <= cnt_q - 8'd1;
          end
        end
        S_RESP: begin
          if (b_hs) begin
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circular_dma_wr_arbiter.sv
// Bench for circular_dma_wr_arbiter: per-scenario tasks, a burst-level reference model
// (round-robin winner, beat count, sticky error flags) and randomized AXI handshaking.
module tb_circular_dma_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] s_awaddr[2];
  logic [7:0]    s_awlen[2];
  logic [DW-1:0] s_wdata[2];
  logic [1:0]    s_awvalid, s_wlast, s_wvalid, s_bready;
  logic [1:0]    s_awready, s_wready, s_bvalid;
  logic [1:0]    s0_bresp, s1_bresp;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic          m_awvalid, m_awready;
  logic [DW-1:0] m_wdata;
  logic          m_wlast, m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;
  logic          grant, busy;
  logic [1:0]    err_wlast;

  circular_dma_wr_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]), .s0_axi_awvalid(s_awvalid[0]),
    .s0_axi_awready(s_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wlast(s_wlast[0]),
    .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s0_bresp),
    .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]), .s1_axi_awvalid(s_awvalid[1]),
    .s1_axi_awready(s_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wlast(s_wlast[1]),
    .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s1_bresp),
    .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]),
    .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .grant(grant), .busy(busy), .err_wlast(err_wlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic          last_g;
  logic [1:0]    err_m;
  logic [AW-1:0] b_addr[2];
  logic [7:0]    b_len[2];
  int            b_bad[2];
  logic [31:0]   wbase[2];
  int            beat[2];

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    for (int n = 0; n < 2; n++) begin
      s_awaddr[n] = '0; s_awlen[n] = '0; s_wdata[n] = '0;
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  // mode 0: always ready; 1: random handshakes; 2: B held with bready low for 10 cycles
  task automatic serve(input logic [1:0] req, input int mode);
    logic [1:0]  pend;
    logic        g, o;
    int          p, cyc, bcyc;
    logic [10:0] obs, expv;
    pend = req;
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) begin
      if (req[n]) begin
        s_awaddr[n] = b_addr[n]; s_awlen[n] = b_len[n]; s_awvalid[n] = 1'b1;
        beat[n] = 0; wbase[n] = $urandom;
      end
    end
    while (pend != 2'b00) begin
      g = (pend == 2'b11) ? ~last_g : pend[1];
      o = ~g;
      p = 0; cyc = 0; bcyc = 0;
      while (p != 4 && cyc < 3000) begin
        m_awready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        m_wready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (p == 3) begin
          if (!m_bvalid) begin
            m_bvalid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            m_bresp  = (mode == 0) ? 2'b00 : 2'($urandom_range(0, 3));
          end
        end else begin
          m_bvalid = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
          if (pend[n]) begin
            s_wvalid[n] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wdata[n]  = {wbase[n], 32'(beat[n])};
            s_wlast[n]  = (beat[n] == int'(b_len[n])) || (beat[n] == b_bad[n]);
          end else begin
            s_wvalid[n] = 1'b0; s_wlast[n] = 1'b0;
          end
        end
        if (p == 1) s_awvalid[g] = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (p >= 2) s_awvalid[g] = 1'b0;
        s_bready[g] = (mode == 2) ? (bcyc >= 10) : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        s_bready[o] = 1'b0;
        @(negedge clk);
        expv = '0;
        expv[10] = (p != 0);
        expv[9]  = (p == 1) && s_awvalid[g];
        expv[8]  = (p == 2) && s_wvalid[g];
        expv[7]  = (p == 2) && (beat[g] == int'(b_len[g]));
        expv[6]  = (p == 3) && s_bready[g];
        if (p == 1) expv[g ? 4 : 5] = m_awready;
        if (p == 2) expv[g ? 2 : 3] = m_wready;
        if (p == 3) expv[g ? 0 : 1] = m_bvalid;
        obs = {busy, m_awvalid, m_wvalid, m_wlast, m_bready, s_awready[0], s_awready[1],
               s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1]};
        n_checks++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL ctl phase=%0d grant_exp=%0d beat=%0d: got %b expected %b", p, g, beat[g], obs, expv);
        end
        if (p != 0) begin
          n_checks++;
          if (grant !== g) begin
            n_fail++;
            $display("FAIL grant phase=%0d: got %0d expected %0d", p, grant, g);
          end
        end
        if (p == 1 && s_awvalid[g]) begin
          n_checks++;
          if ({m_awaddr, m_awlen} !== {b_addr[g], b_len[g]}) begin
            n_fail++;
            $display("FAIL aw_payload: got %h/%0d expected %h/%0d", m_awaddr, m_awlen, b_addr[g], b_len[g]);
          end
        end
        if (p == 2 && s_wvalid[g] && m_wready) begin
          n_checks++;
          if (m_wdata !== {wbase[g], 32'(beat[g])}) begin
            n_fail++;
            $display("FAIL wdata beat=%0d: got %h expected %h", beat[g], m_wdata, {wbase[g], 32'(beat[g])});
          end
        end
        if (p == 3 && m_bvalid) begin
          n_checks++;
          if ((g ? s1_bresp : s0_bresp) !== m_bresp) begin
            n_fail++;
            $display("FAIL bresp: got %0d expected %0d", g ? s1_bresp : s0_bresp, m_bresp);
          end
        end
        case (p)
          0: p = 1;
          1: if (s_awvalid[g] && m_awready) p = 2;
          2: if (s_wvalid[g] && m_wready) begin
               if (beat[g] == int'(b_len[g])) p = 3;
               beat[g]++;
             end
          3: begin
               bcyc++;
               if (m_bvalid && s_bready[g]) p = 4;
             end
          default: ;
        endcase
        @(posedge clk); #1;
        cyc++;
      end
      if (p != 4) begin
        n_checks++; n_fail++;
        $display("FAIL burst_timeout requester=%0d: stuck in phase %0d expected completion", g, p);
        clear_inputs();
        return;
      end
      last_g = g;
      if (b_bad[g] >= 0 && b_bad[g] < int'(b_len[g])) err_m[g] = 1'b1;
      pend[g] = 1'b0;
      s_wvalid[g] = 1'b0; s_wlast[g] = 1'b0; s_bready[g] = 1'b0; m_bvalid = 1'b0;
      n_checks++;
      if (err_wlast !== err_m) begin
        n_fail++;
        $display("FAIL err_wlast after burst of %0d: got %b expected %b", g, err_wlast, err_m);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    s_wdata[0] = {$urandom, $urandom}; s_wdata[1] = {$urandom, $urandom};
    s_awaddr[0] = 32'hdead_beef; s_awlen[0] = 8'hff;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_awaddr, m_awlen, m_wdata, s0_bresp, s1_bresp} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h/%h/%h/%0d/%0d expected all zero", m_awaddr, m_awlen, m_wdata, s0_bresp, s1_bresp);
    end
    n_checks++;
    if ({m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 0", {m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid});
    end
    n_checks++;
    if ({grant, busy, err_wlast} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: got grant=%0d busy=%0d err=%b expected 0/0/00", grant, busy, err_wlast);
    end
    clear_inputs();
    last_g = 1'b1; err_m = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    b_addr[0] = 32'h0000_1000; b_len[0] = 8'd3; b_bad[0] = -1;
    serve(2'b01, 0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 2; n++) begin
        b_addr[n] = $urandom; b_len[n] = 8'($urandom_range(0, 7)); b_bad[n] = -1;
      end
      serve(2'b11, 1);
    end
  endtask

  task automatic test_len0();
    b_addr[0] = 32'h0000_2000; b_len[0] = 8'd0; b_bad[0] = -1;
    serve(2'b01, 1);
    serve(2'b01, 1);
  endtask

  task automatic test_bad_wlast();
    b_addr[1] = 32'h0000_3000; b_len[1] = 8'd3; b_bad[1] = 1;
    serve(2'b10, 0);
  endtask

  task automatic test_b_stall();
    b_addr[0] = 32'h0000_4000; b_len[0] = 8'd1; b_bad[0] = -1;
    b_addr[1] = 32'h0000_5000; b_len[1] = 8'd2; b_bad[1] = -1;
    serve(2'b11, 2);
  endtask

  task automatic test_long();
    b_addr[1] = 32'hffff_f000; b_len[1] = 8'd255; b_bad[1] = -1;
    serve(2'b10, 0);
  endtask

  task automatic test_random();
    logic [1:0] req;
    for (int it = 0; it < 8; it++) begin
      req = 2'($urandom_range(1, 3));
      for (int n = 0; n < 2; n++) begin
        b_addr[n] = $urandom;
        b_len[n]  = 8'($urandom_range(0, 15));
        b_bad[n]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(b_len[n]))) : -1;
      end
      serve(req, 1);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    s_awaddr[0] = 32'h0000_6000; s_awlen[0] = 8'd7; s_awvalid[0] = 1'b1;
    s_wvalid[0] = 1'b1; s_wdata[0] = {$urandom, $urandom};
    m_awready = 1'b1; m_wready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({busy, m_wvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_burst_active: got busy=%0d wvalid=%0d expected 1/1", busy, m_wvalid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid, busy, grant} !== 12'd0
        || m_wdata !== '0 || err_wlast !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got ctl=%b wdata=%h err=%b expected all zero",
               {m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid, busy, grant}, m_wdata, err_wlast);
    end
    clear_inputs();
    last_g = 1'b1; err_m = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      b_addr[n] = $urandom; b_len[n] = 8'($urandom_range(0, 5)); b_bad[n] = -1;
    end
    serve(2'b11, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    last_g = 1'b1; err_m = 2'b00;
    test_reset();
    test_single();
    test_back_to_back();
    test_len0();
    test_bad_wlast();
    test_b_stall();
    test_long();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
